// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one request in flight to instruction memory
// and buffers returned words in a small FIFO feeding the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        stall,
    input  logic        shouldBranch,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic        instrValid,
    output logic [31:0] instruction,
    output logic [31:0] instrPc,
    output logic        misalignedTarget
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetchPc;
    logic [31:0]   reqPc;
    logic          outstanding;
    logic          discard;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic [31:0]   qInstr [QUEUE_DEPTH];
    logic [31:0]   qPc    [QUEUE_DEPTH];

    logic          room;
    logic          respFire;
    logic          accept;
    logic          push;
    logic          pop;

    always_comb begin
        // A buffered entry plus the in-flight one must still fit, so a push never overflows.
        room        = (count + {{(CW-1){1'b0}}, outstanding}) < CW'(QUEUE_DEPTH);
        imemReq     = resetN && !shouldBranch && room &&
                      (!outstanding || (imemRespValid && !discard));
        imemAddr    = fetchPc;
        instrValid  = (count != '0) && !shouldBranch;
        instruction = qInstr[rdPtr];
        instrPc     = qPc[rdPtr];
        respFire    = imemRespValid && outstanding;
        accept      = imemReq && imemReady;
        push        = respFire && !discard && !shouldBranch;
        pop         = instrValid && !stall;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fetchPc          <= RESET_PC;
            reqPc            <= '0;
            outstanding      <= 1'b0;
            discard          <= 1'b0;
            rdPtr            <= '0;
            wrPtr            <= '0;
            count            <= '0;
            misalignedTarget <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                qInstr[i] <= '0;
                qPc[i]    <= '0;
            end
        end else begin
            misalignedTarget <= shouldBranch && (branchTarget[1:0] != 2'b00);

            if (accept) begin
                reqPc   <= fetchPc;
                fetchPc <= fetchPc + 32'd4;
            end
            if (accept)
                outstanding <= 1'b1;
            else if (respFire)
                outstanding <= 1'b0;

            if (shouldBranch) begin
                fetchPc <= {branchTarget[31:2], 2'b00};
                count   <= '0;
                rdPtr   <= '0;
                wrPtr   <= '0;
                // The in-flight wrong-path word must be dropped when it finally returns.
                if (outstanding && !imemRespValid)
                    discard <= 1'b1;
                else if (respFire)
                    discard <= 1'b0;
            end else begin
                if (respFire && discard)
                    discard <= 1'b0;
                if (push) begin
                    qInstr[wrPtr] <= imemRespData;
                    qPc[wrPtr]    <= reqPc;
                    wrPtr         <= wrPtr + 1'b1;
                end
                if (pop)
                    rdPtr <= rdPtr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based reference model checked every cycle,
// plus literal expectations for the addresses and PCs of each scenario.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        stall = 1'b0;
    logic        shouldBranch = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b1;
    logic        imemRespValid = 1'b0;
    logic [31:0] imemRespData = '0;
    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] instrPc;
    logic        misalignedTarget;

    fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .resetN(resetN), .stall(stall), .shouldBranch(shouldBranch),
        .branchTarget(branchTarget), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemReady(imemReady), .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .instrValid(instrValid), .instruction(instruction), .instrPc(instrPc),
        .misalignedTarget(misalignedTarget)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] mFetchPc, mReqPc;
    bit          mOut, mDisc, mMis;
    ent_t        mq[$];

    // memory stub and observations
    bit          memPend = 0;
    logic [31:0] memAddr = '0;
    int          accCount = 0;
    bit          obsReq, obsValid, obsMis, obsResp, obsAcc;
    logic [31:0] obsAddr, obsPc;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mFetchPc = 32'h0; mReqPc = 32'h0;
        mOut = 0; mDisc = 0; mMis = 0;
        mq.delete();
    endtask

    // One clock: drive at negedge, settle, compare against the model, advance model and memory.
    task automatic cycle(input bit st, input bit br, input logic [31:0] tgt,
                         input bit rdy, input bit hold);
        bit expReq, expValid, resp, acc;
        @(negedge clk);
        stall = st; shouldBranch = br; branchTarget = tgt; imemReady = rdy;
        imemRespValid = memPend && !hold;
        imemRespData  = imemRespValid ? memWord(memAddr) : 32'hBAD0_BAD0;
        #1;
        obsReq = imemReq; obsAddr = imemAddr; obsValid = instrValid;
        obsPc = instrPc; obsMis = misalignedTarget; obsResp = imemRespValid;

        expReq   = !br && (!mOut || (imemRespValid && !mDisc)) &&
                   (mq.size() + int'(mOut) < DEPTH);
        expValid = (mq.size() != 0) && !br;
        chk("imemReq", imemReq, expReq);
        if (expReq) chk("imemAddr", imemAddr, mFetchPc);
        chk("instrValid", instrValid, expValid);
        if (expValid) begin
            chk("instrPc", instrPc, mq[0].p);
            chk("instruction", instruction, mq[0].i);
        end
        chk("misalignedTarget", misalignedTarget, mMis);

        resp = imemRespValid && mOut;
        acc  = expReq && rdy;
        if (br) begin
            mq.delete();
            if (mOut && !imemRespValid) mDisc = 1;
            else if (resp) mDisc = 0;
            if (resp) mOut = 0;
            mFetchPc = {tgt[31:2], 2'b00};
            mMis = (tgt[1:0] != 2'b00);
        end else begin
            mMis = 0;
            if (expValid && !st) void'(mq.pop_front());
            if (resp) begin
                if (!mDisc) mq.push_back('{imemRespData, mReqPc});
                else mDisc = 0;
            end
            if (acc) begin
                mReqPc = mFetchPc; mFetchPc = mFetchPc + 32'd4; mOut = 1;
            end else if (resp) begin
                mOut = 0;
            end
        end

        obsAcc = imemReq && rdy;
        if (imemRespValid) memPend = 0;
        if (obsAcc) begin
            memPend = 1; memAddr = imemAddr; accCount++;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        resetN = 1'b0; shouldBranch = 1'b0; stall = 1'b0; imemRespValid = 1'b0;
        #1;
        chk("rst imemReq", imemReq, 0);
        chk("rst instrValid", instrValid, 0);
        chk("rst instruction", instruction, 0);
        chk("rst instrPc", instrPc, 0);
        chk("rst misaligned", misalignedTarget, 0);
        repeat (2) @(posedge clk);
        #2 resetN = 1'b1;
        modelReset();
    endtask

    initial begin
        int n;
        bit found, gotAcc;
        modelReset();

        // back-to-back fetch with a 1-cycle memory
        doReset();
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 0, 1, 0);
            chk("s1 addr", obsAddr, 32'(4 * k));
            if (k >= 2) begin
                chk("s1 valid", obsValid, 1);
                chk("s1 pc", obsPc, 32'(4 * (k - 2)));
            end
        end

        // decode stalled: queue fills to DEPTH then requests stop
        doReset();
        accCount = 0;
        for (int k = 0; k < 10; k++) cycle(1, 0, 0, 1, 0);
        chk("s2 buffered", accCount, 4);
        chk("s2 req idle", obsReq, 0);
        n = 0; gotAcc = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(0, 0, 0, 1, 0);
            if (obsValid && n < 4) begin
                chk("s2 order", obsPc, 32'(4 * n));
                n++;
            end
            if (obsAcc && !gotAcc) begin
                chk("s2 resume", obsAddr, 32'h10);
                gotAcc = 1;
            end
        end
        chk("s2 delivered", n, 4);

        // redirect while 0x20 is in flight; its data must be dropped
        doReset();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(0, 0, 0, 1, 0);
            if (obsAcc && obsAddr == 32'h20) found = 1;
        end
        chk("s3 reached 0x20", found, 1);
        cycle(0, 1, 32'h100, 1, 1);
        chk("s3 redirect valid", obsValid, 0);
        chk("s3 redirect req", obsReq, 0);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle(0, 0, 0, 1, 0);
            if (obsReq) begin chk("s3 target addr", obsAddr, 32'h100); found = 1; end
        end
        chk("s3 target issued", found, 1);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle(0, 0, 0, 1, 0);
            if (obsValid) begin chk("s3 first pc", obsPc, 32'h100); found = 1; end
        end
        chk("s3 target delivered", found, 1);

        // redirect coinciding with a response into a nearly full queue
        doReset();
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 1, 0);
        cycle(1, 1, 32'h40, 1, 0);
        chk("s4 resp in redirect", obsResp, 1);
        cycle(0, 0, 0, 1, 0);
        chk("s4 flushed", obsValid, 0);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle(0, 0, 0, 1, 0);
            if (obsValid) begin chk("s4 first pc", obsPc, 32'h40); found = 1; end
        end
        chk("s4 target delivered", found, 1);

        // misaligned target: aligned restart and one-cycle flag
        cycle(0, 1, 32'h203, 1, 0);
        cycle(0, 0, 0, 1, 0);
        chk("s5 misaligned pulse", obsMis, 1);
        chk("s5 restart req", obsReq, 1);
        chk("s5 restart addr", obsAddr, 32'h200);
        cycle(0, 0, 0, 1, 0);
        chk("s5 misaligned clear", obsMis, 0);

        // PC increment wraps at 2^32
        cycle(0, 1, 32'hFFFF_FFFC, 1, 0);
        cycle(0, 0, 0, 1, 0);
        chk("s6 top addr", obsAddr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 1, 0);
        chk("s6 wrapped addr", obsAddr, 32'h0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);

        // memory not ready: request held stable, then reset mid-wait
        doReset();
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 0, 0);
            chk("s7 held req", obsReq, 1);
            chk("s7 held addr", obsAddr, 32'hC);
        end
        doReset();
        cycle(0, 0, 0, 1, 0);
        chk("s7 restart req", obsReq, 1);
        chk("s7 restart addr", obsAddr, 32'h0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
